// File: rtl/waveform_config_ctrl_if.sv
// Register-access bus between a host and the waveform configuration controller.
// Latency: reads return one cycle after the read strobe; writes take effect at the strobe edge.
// Backpressure: none; every strobe is accepted in the cycle it is presented.
//
// Signals: int_we_i/int_re_i single-cycle strobes, int_addr_i 4-bit address,
//          int_data_i write data, int_data_o read data, int_rd_valid_o read data valid.
interface waveform_config_ctrl_if;
    logic       int_we_i;
    logic       int_re_i;
    logic [3:0] int_addr_i;
    logic [7:0] int_data_i;
    logic [7:0] int_data_o;
    logic       int_rd_valid_o;

    // Host side drives strobes, address and write data.
    modport master (
        output int_we_i, int_re_i, int_addr_i, int_data_i,
        input  int_data_o, int_rd_valid_o
    );

    // Controller side answers with read data.
    modport slave (
        input  int_we_i, int_re_i, int_addr_i, int_data_i,
        output int_data_o, int_rd_valid_o
    );
endinterface

// File: rtl/waveform_config_ctrl.sv
// Two-channel waveform config: shadow registers, committed to active outputs at period wrap.
// Latency: read data 1 cycle after strobe; commit applies 1 cycle after a wrap (or after commit if disabled).
// Backpressure: none; register strobes always accepted, a write wins over a simultaneous read.
//
// Ports: sys_clk_i/sys_rst_i clock and async active-low reset; bus register access interface;
//        chN_wrap_i end-of-period pulse; chN_en_o/chN_sel_o/chN_psc_o active config; chN_upd_o apply pulse.
module waveform_config_ctrl #(
    parameter int PSC_WIDTH = 24,
    parameter int PSC_MIN   = 2
) (
    input  logic                 sys_clk_i,
    input  logic                 sys_rst_i,
    waveform_config_ctrl_if.slave bus,
    input  logic                 ch1_wrap_i,
    input  logic                 ch2_wrap_i,
    output logic                 ch1_en_o,
    output logic                 ch2_en_o,
    output logic [PSC_WIDTH-1:0] ch1_psc_o,
    output logic [PSC_WIDTH-1:0] ch2_psc_o,
    output logic [1:0]           ch1_sel_o,
    output logic [1:0]           ch2_sel_o,
    output logic                 ch1_upd_o,
    output logic                 ch2_upd_o
);

    typedef enum logic [1:0] {ST_IDLE, ST_PENDING, ST_APPLY} state_t;

    localparam logic [PSC_WIDTH-1:0] PSC_FLOOR  = PSC_WIDTH'(PSC_MIN);
    localparam logic [23:0]          SHADOW_RST = 24'(PSC_MIN);

    // Index 0 is channel 1, index 1 is channel 2.
    logic [1:0]                shd_en;
    logic [1:0][1:0]           shd_sel;
    logic [1:0][23:0]          shd_psc;
    logic [1:0]                act_en;
    logic [1:0][1:0]           act_sel;
    logic [1:0][PSC_WIDTH-1:0] act_psc;

    state_t     state     [2];
    state_t     state_nxt [2];
    logic [1:0] enter_apply;
    logic [1:0] pending;
    logic [1:0] wrap;
    logic [1:0] commit;
    logic [7:0] rd_mux;
    logic       rd_go;

    // Shadow PSC is kept at full 24-bit register width so it reads back
    // unmodified; the floor is only applied on the way to the datapath.
    function automatic logic [PSC_WIDTH-1:0] psc_floor(input logic [23:0] v);
        logic [PSC_WIDTH-1:0] t;
        t = PSC_WIDTH'(v);
        return (t < PSC_FLOOR) ? PSC_FLOOR : t;
    endfunction

    assign wrap   = {ch2_wrap_i, ch1_wrap_i};
    assign commit = (bus.int_we_i && bus.int_addr_i == 4'h7) ? bus.int_data_i[1:0] : 2'b00;
    assign rd_go  = bus.int_re_i && !bus.int_we_i;

    // Shadow registers
    always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
        if (!sys_rst_i) begin
            shd_en  <= '0;
            shd_sel <= '0;
            shd_psc <= {SHADOW_RST, SHADOW_RST};
        end else if (bus.int_we_i) begin
            case (bus.int_addr_i)
                4'h0: begin
                    shd_en     <= bus.int_data_i[1:0];
                    shd_sel[0] <= bus.int_data_i[3:2];
                    shd_sel[1] <= bus.int_data_i[5:4];
                end
                4'h1:    shd_psc[0][7:0]   <= bus.int_data_i;
                4'h2:    shd_psc[0][15:8]  <= bus.int_data_i;
                4'h3:    shd_psc[0][23:16] <= bus.int_data_i;
                4'h4:    shd_psc[1][7:0]   <= bus.int_data_i;
                4'h5:    shd_psc[1][15:8]  <= bus.int_data_i;
                4'h6:    shd_psc[1][23:16] <= bus.int_data_i;
                default: ;
            endcase
        end
    end

    // Read path
    always_comb begin
        rd_mux = '0;
        case (bus.int_addr_i)
            4'h0:    rd_mux = {2'b00, shd_sel[1], shd_sel[0], shd_en};
            4'h1:    rd_mux = shd_psc[0][7:0];
            4'h2:    rd_mux = shd_psc[0][15:8];
            4'h3:    rd_mux = shd_psc[0][23:16];
            4'h4:    rd_mux = shd_psc[1][7:0];
            4'h5:    rd_mux = shd_psc[1][15:8];
            4'h6:    rd_mux = shd_psc[1][23:16];
            4'h8:    rd_mux = {4'b0000, act_en, pending};
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
        if (!sys_rst_i) begin
            bus.int_data_o     <= '0;
            bus.int_rd_valid_o <= 1'b0;
        end else begin
            bus.int_rd_valid_o <= rd_go;
            bus.int_data_o     <= rd_go ? rd_mux : 8'h00;
        end
    end

    // Commit FSMs
    always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
        if (!sys_rst_i) begin
            for (int i = 0; i < 2; i++) state[i] <= ST_IDLE;
        end else begin
            for (int i = 0; i < 2; i++) state[i] <= state_nxt[i];
        end
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            state_nxt[i]   = state[i];
            enter_apply[i] = 1'b0;
            pending[i]     = (state[i] == ST_PENDING);
            case (state[i])
                ST_IDLE: begin
                    if (commit[i]) state_nxt[i] = ST_PENDING;
                end
                ST_PENDING: begin
                    // A disabled channel has no period to protect, so it
                    // applies on the cycle after the commit.
                    if (wrap[i] || !act_en[i]) begin
                        state_nxt[i]   = ST_APPLY;
                        enter_apply[i] = 1'b1;
                    end
                end
                ST_APPLY: begin
                    state_nxt[i] = commit[i] ? ST_PENDING : ST_IDLE;
                end
                default: state_nxt[i] = ST_IDLE;
            endcase
        end
    end

    // Active config loads on the edge entering APPLY, so the shadow is
    // sampled before any write landing in the APPLY cycle itself.
    always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
        if (!sys_rst_i) begin
            act_en  <= '0;
            act_sel <= '0;
            act_psc <= {PSC_FLOOR, PSC_FLOOR};
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (enter_apply[i]) begin
                    act_en[i]  <= shd_en[i];
                    act_sel[i] <= shd_sel[i];
                    act_psc[i] <= psc_floor(shd_psc[i]);
                end
            end
        end
    end

    assign ch1_en_o  = act_en[0];
    assign ch2_en_o  = act_en[1];
    assign ch1_sel_o = act_sel[0];
    assign ch2_sel_o = act_sel[1];
    assign ch1_psc_o = act_psc[0];
    assign ch2_psc_o = act_psc[1];
    assign ch1_upd_o = (state[0] == ST_APPLY);
    assign ch2_upd_o = (state[1] == ST_APPLY);

endmodule

// File: tb/tb_waveform_config_ctrl.sv
// Directed bench for waveform_config_ctrl.
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled there too.
// Backpressure: not applicable; the bus has no stall.
module tb_waveform_config_ctrl;

    logic        sys_clk_i;
    logic        sys_rst_i;
    logic        ch1_wrap_i, ch2_wrap_i;
    logic        ch1_en_o, ch2_en_o;
    logic [23:0] ch1_psc_o, ch2_psc_o;
    logic [1:0]  ch1_sel_o, ch2_sel_o;
    logic        ch1_upd_o, ch2_upd_o;

    int n_tests = 0;
    int n_fail  = 0;

    waveform_config_ctrl_if bus ();

    waveform_config_ctrl #(.PSC_WIDTH(24), .PSC_MIN(2)) dut (
        .sys_clk_i  (sys_clk_i),
        .sys_rst_i  (sys_rst_i),
        .bus        (bus),
        .ch1_wrap_i (ch1_wrap_i),
        .ch2_wrap_i (ch2_wrap_i),
        .ch1_en_o   (ch1_en_o),
        .ch2_en_o   (ch2_en_o),
        .ch1_psc_o  (ch1_psc_o),
        .ch2_psc_o  (ch2_psc_o),
        .ch1_sel_o  (ch1_sel_o),
        .ch2_sel_o  (ch2_sel_o),
        .ch1_upd_o  (ch1_upd_o),
        .ch2_upd_o  (ch2_upd_o)
    );

    initial sys_clk_i = 1'b0;
    always #5 sys_clk_i = ~sys_clk_i;

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge sys_clk_i);
            #1;
        end
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
        bus.int_addr_i = a;
        bus.int_data_i = d;
        bus.int_we_i   = 1'b1;
        tick(1);
        bus.int_we_i   = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [7:0] d, output logic v);
        bus.int_addr_i = a;
        bus.int_re_i   = 1'b1;
        tick(1);
        bus.int_re_i   = 1'b0;
        d = bus.int_data_o;
        v = bus.int_rd_valid_o;
    endtask

    task automatic test_reset();
        logic [7:0] d;
        logic v;
        n_tests++;
        if (bus.int_data_o !== 8'h00 || bus.int_rd_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_bus: data=%0h valid=%0b expected 0/0", bus.int_data_o, bus.int_rd_valid_o);
        end
        n_tests++;
        if (ch1_psc_o !== 24'd2 || ch1_en_o !== 1'b0 || ch1_upd_o !== 1'b0 || ch2_psc_o !== 24'd2) begin
            n_fail++;
            $display("FAIL reset_outputs: psc1=%0d en1=%0b upd1=%0b psc2=%0d expected 2/0/0/2",
                     ch1_psc_o, ch1_en_o, ch1_upd_o, ch2_psc_o);
        end
        sys_rst_i = 1'b1;
        tick(1);
        bus_read(4'h1, d, v);
        n_tests++;
        if (d !== 8'h02 || v !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_read_psc: data=%0h valid=%0b expected 02/1", d, v);
        end
        tick(1);
        n_tests++;
        if (bus.int_rd_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_valid_single: valid=%0b expected 0", bus.int_rd_valid_o);
        end
    endtask

    task automatic test_disabled_commit();
        logic [7:0] d;
        logic v;
        int seen;
        bus_write(4'h1, 8'h10);
        bus_write(4'h2, 8'h00);
        bus_write(4'h3, 8'h00);
        bus_write(4'h0, 8'h05);
        bus_write(4'h7, 8'h01);
        seen = 0;
        for (int k = 1; k <= 3; k++) begin
            if (ch1_upd_o === 1'b1 && seen == 0) seen = k;
            if (k < 3) tick(1);
        end
        n_tests++;
        if (seen == 0 || seen > 2) begin
            n_fail++;
            $display("FAIL disabled_upd_latency: first pulse sample=%0d expected 1..2", seen);
        end
        n_tests++;
        if (ch1_psc_o !== 24'd16 || ch1_en_o !== 1'b1 || ch1_sel_o !== 2'd1) begin
            n_fail++;
            $display("FAIL disabled_apply: psc=%0d en=%0b sel=%0d expected 16/1/1", ch1_psc_o, ch1_en_o, ch1_sel_o);
        end
        n_tests++;
        if (ch2_en_o !== 1'b0 || ch2_psc_o !== 24'd2 || ch2_upd_o !== 1'b0) begin
            n_fail++;
            $display("FAIL ch2_untouched: en=%0b psc=%0d upd=%0b expected 0/2/0", ch2_en_o, ch2_psc_o, ch2_upd_o);
        end
        bus_read(4'h0, d, v);
        n_tests++;
        if (d !== 8'h05 || v !== 1'b1) begin
            n_fail++;
            $display("FAIL ctrl_readback: data=%0h valid=%0b expected 05/1", d, v);
        end
    endtask

    task automatic test_wrap_apply();
        logic [7:0] d;
        logic v;
        bus_write(4'h1, 8'h40);
        bus_write(4'h7, 8'h01);
        bus_read(4'h8, d, v);
        n_tests++;
        if (d !== 8'h05 || v !== 1'b1) begin
            n_fail++;
            $display("FAIL status_pending: data=%0h valid=%0b expected 05/1", d, v);
        end
        tick(4);
        n_tests++;
        if (ch1_psc_o !== 24'd16 || ch1_upd_o !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_until_wrap: psc=%0d upd=%0b expected 16/0", ch1_psc_o, ch1_upd_o);
        end
        ch1_wrap_i = 1'b1;
        tick(1);
        ch1_wrap_i = 1'b0;
        n_tests++;
        if (ch1_psc_o !== 24'd64 || ch1_upd_o !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_apply: psc=%0d upd=%0b expected 64/1", ch1_psc_o, ch1_upd_o);
        end
        tick(1);
        n_tests++;
        if (ch1_upd_o !== 1'b0) begin
            n_fail++;
            $display("FAIL upd_one_cycle: upd=%0b expected 0", ch1_upd_o);
        end
    endtask

    task automatic test_zero_psc();
        logic [7:0] d;
        logic v;
        bus_write(4'h4, 8'h00);
        bus_write(4'h5, 8'h00);
        bus_write(4'h6, 8'h00);
        bus_write(4'h7, 8'h02);
        tick(3);
        n_tests++;
        if (ch2_psc_o !== 24'd2) begin
            n_fail++;
            $display("FAIL psc_floor: psc2=%0d expected 2", ch2_psc_o);
        end
        bus_read(4'h4, d, v);
        n_tests++;
        if (d !== 8'h00 || v !== 1'b1) begin
            n_fail++;
            $display("FAIL shadow_no_clamp: data=%0h valid=%0b expected 00/1", d, v);
        end
        bus_read(4'h9, d, v);
        n_tests++;
        if (d !== 8'h00 || v !== 1'b1) begin
            n_fail++;
            $display("FAIL unmapped_read: data=%0h valid=%0b expected 00/1", d, v);
        end
    endtask

    task automatic test_same_cycle_wrap();
        bus_write(4'h1, 8'h20);
        ch1_wrap_i = 1'b1;
        bus_write(4'h7, 8'h01);
        ch1_wrap_i = 1'b0;
        tick(3);
        n_tests++;
        if (ch1_psc_o !== 24'd64 || ch1_upd_o !== 1'b0) begin
            n_fail++;
            $display("FAIL same_cycle_wrap_ignored: psc=%0d upd=%0b expected 64/0", ch1_psc_o, ch1_upd_o);
        end
        ch1_wrap_i = 1'b1;
        tick(1);
        ch1_wrap_i = 1'b0;
        n_tests++;
        if (ch1_psc_o !== 24'd32 || ch1_upd_o !== 1'b1) begin
            n_fail++;
            $display("FAIL next_wrap_apply: psc=%0d upd=%0b expected 32/1", ch1_psc_o, ch1_upd_o);
        end
    endtask

    task automatic test_write_read_collision();
        logic [7:0] d;
        logic v;
        bus.int_addr_i = 4'h2;
        bus.int_data_i = 8'h01;
        bus.int_we_i   = 1'b1;
        bus.int_re_i   = 1'b1;
        tick(1);
        bus.int_we_i   = 1'b0;
        bus.int_re_i   = 1'b0;
        n_tests++;
        if (bus.int_rd_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL collision_no_valid: valid=%0b expected 0", bus.int_rd_valid_o);
        end
        bus_read(4'h2, d, v);
        n_tests++;
        if (d !== 8'h01 || v !== 1'b1) begin
            n_fail++;
            $display("FAIL collision_write_done: data=%0h valid=%0b expected 01/1", d, v);
        end
    endtask

    task automatic test_reset_pending();
        logic [7:0] d;
        logic v;
        bus_write(4'h0, 8'h07);
        bus_write(4'h7, 8'h02);
        tick(3);
        n_tests++;
        if (ch2_en_o !== 1'b1) begin
            n_fail++;
            $display("FAIL ch2_enable: en2=%0b expected 1", ch2_en_o);
        end
        bus_write(4'h7, 8'h02);
        bus_read(4'h8, d, v);
        n_tests++;
        if (d !== 8'h0E || v !== 1'b1) begin
            n_fail++;
            $display("FAIL status_ch2_pending: data=%0h valid=%0b expected 0e/1", d, v);
        end
        sys_rst_i = 1'b0;
        #2;
        n_tests++;
        if (ch2_en_o !== 1'b0 || ch1_en_o !== 1'b0 || ch1_psc_o !== 24'd2 ||
            ch2_upd_o !== 1'b0 || bus.int_rd_valid_o !== 1'b0 || bus.int_data_o !== 8'h00) begin
            n_fail++;
            $display("FAIL async_reset: en1=%0b en2=%0b psc1=%0d upd2=%0b valid=%0b data=%0h expected 0/0/2/0/0/00",
                     ch1_en_o, ch2_en_o, ch1_psc_o, ch2_upd_o, bus.int_rd_valid_o, bus.int_data_o);
        end
        tick(2);
        sys_rst_i = 1'b1;
        tick(1);
        bus_read(4'h8, d, v);
        n_tests++;
        if (d !== 8'h00 || v !== 1'b1) begin
            n_fail++;
            $display("FAIL status_after_reset: data=%0h valid=%0b expected 00/1", d, v);
        end
        ch2_wrap_i = 1'b1;
        tick(1);
        ch2_wrap_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (ch2_upd_o !== 1'b0 || ch2_psc_o !== 24'd2) begin
                n_fail++;
                $display("FAIL pending_discarded: cycle=%0d upd2=%0b psc2=%0d expected 0/2", k, ch2_upd_o, ch2_psc_o);
            end
            tick(1);
        end
    endtask

    initial begin
        sys_rst_i      = 1'b0;
        ch1_wrap_i     = 1'b0;
        ch2_wrap_i     = 1'b0;
        bus.int_we_i   = 1'b0;
        bus.int_re_i   = 1'b0;
        bus.int_addr_i = 4'h0;
        bus.int_data_i = 8'h00;
        tick(3);
        test_reset();
        test_disabled_commit();
        test_wrap_apply();
        test_zero_psc();
        test_same_cycle_wrap();
        test_write_read_collision();
        test_reset_pending();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
